// File: rtl/simeck_round_ctrl.sv
// ---------------------------------------------------------------------------
// simeck_round_ctrl
//
// Round sequencer for a Simeck block-cipher datapath. For every requested
// block it pulses key_load once, then drives NROUNDS consecutive round
// enables together with the round index and the round-constant bit z.
//
// The round constant comes from a 5-bit LFSR s[4:0] with feedback s4^s1
// (primitive, period 31). Encryption walks the LFSR forward from the seed.
// Decryption first advances the LFSR NROUNDS-1 steps without running rounds
// (PRIME). It then walks backwards with the inverse step, so the decrypt
// constants are the encrypt constants in reverse order, for any NROUNDS.
//
// Parameter
//   NROUNDS       rounds per block, legal range 2..63
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   i_start       request one block operation (only looked at in IDLE)
//   i_mode        0 = encrypt, 1 = decrypt, captured together with i_start
//   i_abort       (SIMECK_CTRL_ABORT_EN builds only) cancel the running
//                 operation from PRIME, LOAD or RUN
//   o_busy        high in every state except IDLE
//   o_key_load    one-cycle pulse: datapath loads text and key
//   o_round_en    datapath executes one round this cycle
//   o_round_idx   index of the round executed while o_round_en is high
//   o_z_out       round-constant bit, valid while o_round_en is high
//   o_done        one-cycle pulse after the last round
//
// Configuration macro
//   SIMECK_CTRL_ABORT_EN   adds the i_abort input and the abort path
// ---------------------------------------------------------------------------
module simeck_round_ctrl #(
  parameter int NROUNDS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_mode,
`ifdef SIMECK_CTRL_ABORT_EN
  input  logic       i_abort,
`endif
  output logic       o_busy,
  output logic       o_key_load,
  output logic       o_round_en,
  output logic [5:0] o_round_idx,
  output logic       o_z_out,
  output logic       o_done
);

  localparam logic [4:0] SEED       = 5'b11111;
  localparam logic [5:0] LAST_PRIME = 6'(NROUNDS - 2);
  localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [4:0] r_s;
  logic [5:0] r_cnt;
  logic       r_mode;
  logic       r_busy;
  logic       r_keyLoad;
  logic       r_roundEn;
  logic       r_done;
  logic [5:0] r_roundIdx;
  logic       r_z;

  logic [4:0] w_sFwd;
  logic [4:0] w_sRev;
  logic [4:0] w_sRun;
  logic       w_abort;
  logic       w_abortHit;

  // Forward and inverse LFSR steps. The inverse recovers the old s4 from
  // the new s0 (= old s4 ^ old s1) and the new s2 (= old s1). The
  // polynomial is primitive, so starting from the all-ones seed the
  // all-zero state can never appear in either direction.
  assign w_sFwd = {r_s[3:0], r_s[4] ^ r_s[1]};
  assign w_sRev = {r_s[0] ^ r_s[2], r_s[4:1]};
  assign w_sRun = r_mode ? w_sRev : w_sFwd;

`ifdef SIMECK_CTRL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only matters while an operation is in flight. In IDLE, start
  // takes priority. In DONE, the operation has already completed.
  assign w_abortHit = w_abort &&
                      ((r_state == S_PRIME) || (r_state == S_LOAD) ||
                       (r_state == S_RUN));

  // Single sequencer. All outputs are registered and are set on the edge
  // that enters the cycle they describe. Index and z only load when the
  // next cycle is a round, so they hold their last value between
  // operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s        <= SEED;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_keyLoad  <= 1'b0;
      r_roundEn  <= 1'b0;
      r_done     <= 1'b0;
      r_roundIdx <= '0;
      r_z        <= 1'b0;
    end else begin
      r_keyLoad <= 1'b0;
      r_roundEn <= 1'b0;
      r_done    <= 1'b0;

      if (w_abortHit) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_s     <= SEED;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_mode <= i_mode;
              r_s    <= SEED;
              r_cnt  <= '0;
              r_busy <= 1'b1;
              if (i_mode) begin
                r_state <= S_PRIME;
              end else begin
                r_state   <= S_LOAD;
                r_keyLoad <= 1'b1;
              end
            end
          end

          // Advance the LFSR to the constant of the last round, so RUN can
          // walk it backwards. The counter is cleared for RUN on exit.
          S_PRIME: begin
            r_s <= w_sFwd;
            if (r_cnt == LAST_PRIME) begin
              r_cnt     <= '0;
              r_state   <= S_LOAD;
              r_keyLoad <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end

          // Key/text load cycle. s and the counter are left alone. This
          // edge prepares the first round's index and constant.
          S_LOAD: begin
            r_state    <= S_RUN;
            r_roundEn  <= 1'b1;
            r_roundIdx <= r_mode ? LAST_ROUND : 6'd0;
            r_z        <= r_s[4];
          end

          // r_cnt counts rounds already executed in this RUN. Each edge
          // steps s and, unless this was the last round, presents the next
          // round's index and constant.
          S_RUN: begin
            r_s <= w_sRun;
            if (r_cnt == LAST_ROUND) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt      <= r_cnt + 6'd1;
              r_roundEn  <= 1'b1;
              r_roundIdx <= r_mode ? (LAST_PRIME - r_cnt) : (r_cnt + 6'd1);
              r_z        <= w_sRun[4];
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_key_load  = r_keyLoad;
  assign o_round_en  = r_roundEn;
  assign o_round_idx = r_roundIdx;
  assign o_z_out     = r_z;
  assign o_done      = r_done;

endmodule

// File: tb/tb_simeck_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simeck_round_ctrl
//
// Testbench for simeck_round_ctrl. DUT A uses the default 32 rounds. DUT B
// uses 37 rounds, so its constant sequence runs past the LFSR period of 31.
//
// Expected constants come from the bit recurrence that the feedback
// s4^s1 implies for the output stream:
//   z[k] = z[k-5] ^ z[k-2], with z[0..4] = 1.
// Expected timing comes from the operation latencies.
// ---------------------------------------------------------------------------
module tb_simeck_round_ctrl;

  localparam int NA = 32;
  localparam int NB = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       startA;
  logic       startB;
  logic       mode;
`ifdef SIMECK_CTRL_ABORT_EN
  logic       abort;
`endif

  logic       busyA, klA, reA, zA, doneA;
  logic [5:0] idxA;
  logic       busyB, klB, reB, zB, doneB;
  logic [5:0] idxB;

  int checks   = 0;
  int failures = 0;

  int         zRef   [0:127];
  int         encZ   [0:63];
  logic       capBusy[0:255];
  logic       capKl  [0:255];
  logic       capRe  [0:255];
  logic       capDone[0:255];
  logic       capZ   [0:255];
  logic [5:0] capIdx [0:255];

  simeck_round_ctrl #(.NROUNDS(NA)) u_dutA (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (startA),
    .i_mode     (mode),
`ifdef SIMECK_CTRL_ABORT_EN
    .i_abort    (abort),
`endif
    .o_busy     (busyA),
    .o_key_load (klA),
    .o_round_en (reA),
    .o_round_idx(idxA),
    .o_z_out    (zA),
    .o_done     (doneA)
  );

  simeck_round_ctrl #(.NROUNDS(NB)) u_dutB (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (startB),
    .i_mode     (mode),
`ifdef SIMECK_CTRL_ABORT_EN
    .i_abort    (1'b0),
`endif
    .o_busy     (busyB),
    .o_key_load (klB),
    .o_round_en (reB),
    .o_round_idx(idxB),
    .o_z_out    (zB),
    .o_done     (doneB)
  );

  // Reference constant stream, derived from the output-bit recurrence
  function automatic void buildRef();
    for (int k = 0; k < 128; k++) begin
      if (k < 5) zRef[k] = 1;
      else       zRef[k] = zRef[k-5] ^ zRef[k-2];
    end
  endfunction

  // Launch one operation on DUT A (sel=0) or B (sel=1). Record the outputs
  // in cycles 1..ncyc, where cycle 0 is the edge that samples start.
  // startCycles > 1 keeps start high. noise toggles start and mode
  // randomly while the DUT is busy.
  task automatic captureOp(input bit sel, input logic m, input int startCycles,
                           input bit noise, input int ncyc);
    @(negedge clk);
    mode = m;
    if (sel) startB = 1'b1; else startA = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (sel) begin
        capBusy[c] = busyB; capKl[c] = klB; capRe[c] = reB;
        capDone[c] = doneB; capZ[c] = zB; capIdx[c] = idxB;
      end else begin
        capBusy[c] = busyA; capKl[c] = klA; capRe[c] = reA;
        capDone[c] = doneA; capZ[c] = zA; capIdx[c] = idxA;
      end
      if (c >= startCycles) begin
        startA = 1'b0;
        startB = 1'b0;
      end
      if (noise && !sel && c >= 2 && c <= 30) begin
        startA = 1'($urandom_range(0, 1));
        mode   = 1'($urandom_range(0, 1));
      end
    end
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic test_reset();
    startA = 1'b0;
    startB = 1'b0;
    mode   = 1'b0;
`ifdef SIMECK_CTRL_ABORT_EN
    abort  = 1'b0;
`endif
    rst_n  = 1'b0;
    #2;
    checks++;
    if ({busyA, klA, reA, doneA} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {busyA, klA, reA, doneA});
    end
    checks++;
    if (idxA !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset_idx: got %0d expected 0", idxA);
    end
    checks++;
    if ({busyB, klB, reB, doneB} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl_b: got %b expected 0000", {busyB, klB, reB, doneB});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_encrypt();
    logic [5:0] first6;
    int klCount, reCount, doneCount, zBad, excl;
    first6 = 6'b111110;
    captureOp(1'b0, 1'b0, 1, 1'b0, 40);
    klCount = 0; reCount = 0; doneCount = 0; zBad = 0; excl = 0;
    for (int c = 1; c <= 40; c++) begin
      klCount   += int'(capKl[c]);
      reCount   += int'(capRe[c]);
      doneCount += int'(capDone[c]);
      if (int'(capKl[c]) + int'(capRe[c]) + int'(capDone[c]) > 1) excl++;
    end
    checks++;
    if (capKl[1] !== 1'b1 || klCount != 1) begin
      failures++;
      $display("[TB] FAIL enc_key_load: got kl1=%b count=%0d expected 1 and 1", capKl[1], klCount);
    end
    checks++;
    if (capRe[1] !== 1'b0 || capRe[2] !== 1'b1 || capRe[33] !== 1'b1 ||
        capRe[34] !== 1'b0 || reCount != NA) begin
      failures++;
      $display("[TB] FAIL enc_round_en: got c1=%b c2=%b c33=%b c34=%b count=%0d expected 0 1 1 0 %0d",
               capRe[1], capRe[2], capRe[33], capRe[34], reCount, NA);
    end
    checks++;
    if (capDone[34] !== 1'b1 || doneCount != 1) begin
      failures++;
      $display("[TB] FAIL enc_done: got d34=%b count=%0d expected 1 and 1", capDone[34], doneCount);
    end
    checks++;
    if (capBusy[1] !== 1'b1 || capBusy[34] !== 1'b1 || capBusy[35] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL enc_busy: got %b%b%b expected 110", capBusy[1], capBusy[34], capBusy[35]);
    end
    checks++;
    if (capIdx[2] !== 6'd0 || capIdx[17] !== 6'd15 || capIdx[33] !== 6'd31) begin
      failures++;
      $display("[TB] FAIL enc_idx: got %0d %0d %0d expected 0 15 31", capIdx[2], capIdx[17], capIdx[33]);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (capZ[2+k] !== first6[5-k]) begin
        failures++;
        $display("[TB] FAIL enc_z_first round %0d: got %b expected %b", k, capZ[2+k], first6[5-k]);
      end
    end
    for (int k = 0; k < NA; k++) begin
      encZ[k] = int'(capZ[2+k]);
      if (encZ[k] != zRef[k]) zBad++;
    end
    checks++;
    if (zBad != 0) begin
      failures++;
      $display("[TB] FAIL enc_z_seq: got %0d wrong bits expected 0", zBad);
    end
    checks++;
    if (capIdx[36] !== 6'd31 || int'(capZ[36]) != zRef[31]) begin
      failures++;
      $display("[TB] FAIL enc_hold: got idx=%0d z=%b expected 31 %0d", capIdx[36], capZ[36], zRef[31]);
    end
    checks++;
    if (excl != 0) begin
      failures++;
      $display("[TB] FAIL enc_exclusive: got %0d overlapping cycles expected 0", excl);
    end
  endtask

  task automatic test_decrypt();
    int klCount, primeRe, doneCount, idxBad, zBad;
    captureOp(1'b0, 1'b1, 1, 1'b0, 70);
    klCount = 0; primeRe = 0; doneCount = 0; idxBad = 0; zBad = 0;
    for (int c = 1; c <= 70; c++) begin
      klCount   += int'(capKl[c]);
      doneCount += int'(capDone[c]);
      if (c <= 32) primeRe += int'(capRe[c]);
    end
    for (int j = 0; j < NA; j++) begin
      if (capRe[33+j] !== 1'b1 || capIdx[33+j] !== 6'(NA-1-j)) idxBad++;
      if (int'(capZ[33+j]) != encZ[NA-1-j]) zBad++;
    end
    checks++;
    if (primeRe != 0 || capBusy[15] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dec_prime: got round_en count=%0d busy=%b expected 0 1", primeRe, capBusy[15]);
    end
    checks++;
    if (capKl[32] !== 1'b1 || klCount != 1) begin
      failures++;
      $display("[TB] FAIL dec_key_load: got kl32=%b count=%0d expected 1 and 1", capKl[32], klCount);
    end
    checks++;
    if (idxBad != 0) begin
      failures++;
      $display("[TB] FAIL dec_idx: got %0d wrong rounds expected 0", idxBad);
    end
    checks++;
    if (zBad != 0) begin
      failures++;
      $display("[TB] FAIL dec_z_reverse: got %0d wrong bits expected 0", zBad);
    end
    checks++;
    if (capDone[65] !== 1'b1 || doneCount != 1 || capRe[65] !== 1'b0 || capBusy[66] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dec_done: got d65=%b count=%0d re65=%b busy66=%b expected 1 1 0 0",
               capDone[65], doneCount, capRe[65], capBusy[66]);
    end
    checks++;
    if (capIdx[67] !== 6'd0) begin
      failures++;
      $display("[TB] FAIL dec_hold: got idx=%0d expected 0", capIdx[67]);
    end
  endtask

  task automatic test_back_to_back();
    int klBad, doneBad;
    bit expKl, expDone;
    captureOp(1'b0, 1'b0, 100, 1'b0, 120);
    klBad = 0; doneBad = 0;
    for (int c = 1; c <= 120; c++) begin
      expKl   = (c == 1) || (c == 36) || (c == 71);
      expDone = (c == 34) || (c == 69) || (c == 104);
      if (capKl[c] !== expKl) klBad++;
      if (capDone[c] !== expDone) doneBad++;
    end
    checks++;
    if (klBad != 0) begin
      failures++;
      $display("[TB] FAIL b2b_key_load: got %0d wrong cycles expected 0", klBad);
    end
    checks++;
    if (doneBad != 0) begin
      failures++;
      $display("[TB] FAIL b2b_done: got %0d wrong cycles expected 0", doneBad);
    end
  endtask

  // Random-mode operations with random start/mode noise while busy,
  // compared cycle by cycle with the latency model
  task automatic test_start_ignored();
    logic m;
    int lat, first, expIdx, bad, doneCount, excl;
    bit expKl, expRe, expDone, expBusy;
    for (int op = 0; op < 6; op++) begin
      m     = 1'($urandom_range(0, 1));
      lat   = m ? 2*NA + 1 : NA + 2;
      first = lat - NA;
      captureOp(1'b0, m, 1, 1'b1, lat + 2);
      bad = 0; doneCount = 0; excl = 0;
      for (int c = 1; c <= lat + 2; c++) begin
        expKl   = (c == first - 1);
        expRe   = (c >= first) && (c <= lat - 1);
        expDone = (c == lat);
        expBusy = (c <= lat);
        if (capKl[c] !== expKl || capRe[c] !== expRe ||
            capDone[c] !== expDone || capBusy[c] !== expBusy) bad++;
        if (expRe) begin
          expIdx = m ? NA - 1 - (c - first) : c - first;
          if (capIdx[c] !== 6'(expIdx) || int'(capZ[c]) != zRef[expIdx]) bad++;
        end
        doneCount += int'(capDone[c]);
        if (int'(capKl[c]) + int'(capRe[c]) + int'(capDone[c]) > 1) excl++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL noisy_op %0d mode %b: got %0d wrong cycles expected 0", op, m, bad);
      end
      checks++;
      if (doneCount != 1 || excl != 0) begin
        failures++;
        $display("[TB] FAIL noisy_done %0d: got done=%0d overlap=%0d expected 1 0", op, doneCount, excl);
      end
    end
  endtask

  task automatic test_reset_mid();
    int doneSeen, zBad;
    @(negedge clk);
    mode   = 1'b0;
    startA = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      startA = 1'b0;
    end
    checks++;
    if (reA !== 1'b1 || idxA !== 6'd10) begin
      failures++;
      $display("[TB] FAIL rst_mid_pre: got re=%b idx=%0d expected 1 10", reA, idxA);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busyA, klA, reA, doneA} !== 4'b0000 || idxA !== 6'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_async: got ctrl=%b idx=%0d expected 0000 0",
               {busyA, klA, reA, doneA}, idxA);
    end
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      doneSeen += int'(doneA) + int'(busyA);
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      doneSeen += int'(doneA) + int'(busyA);
    end
    checks++;
    if (doneSeen != 0) begin
      failures++;
      $display("[TB] FAIL rst_mid_no_done: got %0d busy/done cycles expected 0", doneSeen);
    end
    captureOp(1'b0, 1'b0, 1, 1'b0, 36);
    zBad = 0;
    for (int k = 0; k < NA; k++) if (int'(capZ[2+k]) != zRef[k]) zBad++;
    checks++;
    if (zBad != 0 || capKl[1] !== 1'b1 || capDone[34] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_rerun: got zbad=%0d kl1=%b d34=%b expected 0 1 1", zBad, capKl[1], capDone[34]);
    end
  endtask

  // 37 rounds: the constant stream wraps the 31-state LFSR
  task automatic test_wrap();
    int encB[0:63];
    int zBad, revBad;
    captureOp(1'b1, 1'b0, 1, 1'b0, 42);
    zBad = 0;
    for (int k = 0; k < NB; k++) begin
      encB[k] = int'(capZ[2+k]);
      if (encB[k] != zRef[k] || capIdx[2+k] !== 6'(k)) zBad++;
    end
    checks++;
    if (zBad != 0 || capDone[NB+2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_enc: got %0d wrong rounds done=%b expected 0 1", zBad, capDone[NB+2]);
    end
    captureOp(1'b1, 1'b1, 1, 1'b0, 2*NB + 3);
    revBad = 0;
    for (int j = 0; j < NB; j++) begin
      if (int'(capZ[NB+1+j]) != encB[NB-1-j] || capIdx[NB+1+j] !== 6'(NB-1-j) ||
          capRe[NB+1+j] !== 1'b1) revBad++;
    end
    checks++;
    if (revBad != 0 || capDone[2*NB+1] !== 1'b1 || capKl[NB] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_dec: got %0d wrong rounds done=%b kl=%b expected 0 1 1",
               revBad, capDone[2*NB+1], capKl[NB]);
    end
  endtask

`ifdef SIMECK_CTRL_ABORT_EN
  task automatic test_abort();
    int doneSeen, zBad;
    @(negedge clk);
    mode   = 1'b0;
    startA = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      startA = 1'b0;
    end
    checks++;
    if (reA !== 1'b1 || idxA !== 6'd5) begin
      failures++;
      $display("[TB] FAIL abort_pre: got re=%b idx=%0d expected 1 5", reA, idxA);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busyA, reA, doneA} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL abort_idle: got %b expected 000", {busyA, reA, doneA});
    end
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      doneSeen += int'(doneA);
    end
    checks++;
    if (doneSeen != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got %0d expected 0", doneSeen);
    end
    captureOp(1'b0, 1'b1, 1, 1'b0, 66);
    zBad = 0;
    for (int j = 0; j < NA; j++) if (int'(capZ[33+j]) != zRef[NA-1-j]) zBad++;
    checks++;
    if (zBad != 0 || capDone[65] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_next_dec: got zbad=%0d d65=%b expected 0 1", zBad, capDone[65]);
    end
  endtask
`endif

  initial begin
    buildRef();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_wrap();
`ifdef SIMECK_CTRL_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
